// File: rtl/t_ff_mod_counter_pkg.sv
// Shared definitions for the T-flip-flop modulo counter family: direction
// encodings and the modulus legality check reused by other counters.
package t_ff_mod_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // A modulus is legal when the range 0..modulus-1 fits in `width` bits.
  function automatic bit modulus_ok(input int width, input int modulus);
    return (width >= 1) && (width <= 30) && (modulus >= 2) && (modulus <= (1 << width));
  endfunction

endpackage

// File: rtl/t_ff_mod_counter_t_ff_cell.sv
// Single toggle flip-flop with asynchronous active-high clear.
module t_ff_cell (
  input  logic i_clk,
  input  logic i_clear,
  input  logic i_t,
  output logic o_q,
  output logic o_qbar
);

  logic r_q;

  always_ff @(posedge i_clk or posedge i_clear) begin
    if (i_clear) begin
      r_q <= 1'b0;
    end else if (i_t) begin
      r_q <= ~r_q;
    end
  end

  assign o_q    = r_q;
  assign o_qbar = ~r_q;

endmodule

// File: rtl/t_ff_mod_counter.sv
// Modulo-N up/down counter built from a bank of toggle cells.
// Define T_FF_MOD_COUNTER_SATURATE_EN to hold at the bounds instead of wrapping.
module t_ff_mod_counter
  import t_ff_mod_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             i_clk,
  input  logic             i_clear,
  input  logic             i_sync_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  input  logic             i_up_dn,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_qbar,
  output logic             o_tc,
  output logic             o_wrap,
  output logic             o_load_err
);

  generate
    if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
      $error("t_ff_mod_counter: MODULUS %0d illegal for WIDTH %0d", MODULUS, WIDTH);
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_qbar;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_t;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_wrap_next;
  logic             w_load_err_next;
  logic             r_wrap;
  logic             r_load_err;

  assign w_at_max  = (w_q == MAX_VAL);
  assign w_at_zero = (w_q == '0);

  always_comb begin
    w_next          = w_q;
    w_wrap_next     = 1'b0;
    w_load_err_next = 1'b0;
    if (i_sync_clr) begin
      w_next = '0;
    end else if (i_load) begin
      if ({1'b0, i_load_val} < MOD_EXT) begin
        w_next = i_load_val;
      end else begin
        w_next          = MAX_VAL;
        w_load_err_next = 1'b1;
      end
    end else if (i_en) begin
      if (i_up_dn == DIR_UP) begin
        if (w_at_max) begin
`ifdef T_FF_MOD_COUNTER_SATURATE_EN
          w_next = MAX_VAL;
`else
          w_next      = '0;
          w_wrap_next = 1'b1;
`endif
        end else begin
          w_next = w_q + WIDTH'(1);
        end
      end else begin
        if (w_at_zero) begin
`ifdef T_FF_MOD_COUNTER_SATURATE_EN
          w_next = '0;
`else
          w_next      = MAX_VAL;
          w_wrap_next = 1'b1;
`endif
        end else begin
          w_next = w_q - WIDTH'(1);
        end
      end
    end
  end

  // Each cell flips exactly the bits that differ between now and next.
  assign w_t = w_q ^ w_next;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      t_ff_cell u_cell (
        .i_clk  (i_clk),
        .i_clear(i_clear),
        .i_t    (w_t[gi]),
        .o_q    (w_q[gi]),
        .o_qbar (w_qbar[gi])
      );
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_clear) begin
    if (i_clear) begin
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_wrap     <= w_wrap_next;
      r_load_err <= w_load_err_next;
    end
  end

  assign o_q        = w_q;
  assign o_qbar     = w_qbar;
  assign o_wrap     = r_wrap;
  assign o_load_err = r_load_err;
  assign o_tc       = i_en & (((i_up_dn == DIR_UP) & w_at_max) |
                              ((i_up_dn == DIR_DOWN) & w_at_zero));

endmodule

// File: tb/tb_t_ff_mod_counter.sv
// Self-checking bench for t_ff_mod_counter (WIDTH=4, MODULUS=10); honours
// T_FF_MOD_COUNTER_SATURATE_EN when the design is built with it.
module tb_t_ff_mod_counter;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         clear, sync_clr, load, en, up_dn;
  logic [W-1:0] load_val;
  logic [W-1:0] q, qbar;
  logic         tc, wrap, load_err;

  int checks = 0;
  int errors = 0;

  int m_q = 0;
  int m_wrap = 0;
  int m_lerr = 0;

  t_ff_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .i_clk     (clk),
    .i_clear   (clear),
    .i_sync_clr(sync_clr),
    .i_load    (load),
    .i_load_val(load_val),
    .i_en      (en),
    .i_up_dn   (up_dn),
    .o_q       (q),
    .o_qbar    (qbar),
    .o_tc      (tc),
    .o_wrap    (wrap),
    .o_load_err(load_err)
  );

  always #5 clk = ~clk;

  // Reference model: plain modular arithmetic on integers.
  always @(posedge clk or posedge clear) begin
    if (clear) begin
      m_q = 0; m_wrap = 0; m_lerr = 0;
    end else if (sync_clr) begin
      m_q = 0; m_wrap = 0; m_lerr = 0;
    end else if (load) begin
      m_wrap = 0;
      if (int'(load_val) < M) begin m_q = int'(load_val); m_lerr = 0; end
      else begin m_q = M - 1; m_lerr = 1; end
    end else if (en) begin
      m_lerr = 0;
`ifdef T_FF_MOD_COUNTER_SATURATE_EN
      m_wrap = 0;
      if (up_dn) m_q = (m_q + 1 > M - 1) ? M - 1 : m_q + 1;
      else       m_q = (m_q - 1 < 0) ? 0 : m_q - 1;
`else
      if (up_dn) begin m_q = (m_q + 1) % M;     m_wrap = (m_q == 0)     ? 1 : 0; end
      else       begin m_q = (m_q + M - 1) % M; m_wrap = (m_q == M - 1) ? 1 : 0; end
`endif
    end else begin
      m_wrap = 0; m_lerr = 0;
    end
  end

  function automatic int model_tc();
    return (en && ((up_dn && m_q == M - 1) || (!up_dn && m_q == 0))) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("q",        int'(q),        m_q);
    chk("qbar",     int'(qbar),     (~m_q) & ((1 << W) - 1));
    chk("tc",       int'(tc),       model_tc());
    chk("wrap",     int'(wrap),     m_wrap);
    chk("load_err", int'(load_err), m_lerr);
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int exp_up[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

  initial begin
    clear = 1'b1; sync_clr = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; up_dn = 1'b1;
    #23;
    chk("reset_q",    int'(q),    0);
    chk("reset_qbar", int'(qbar), 15);
    chk("reset_wrap", int'(wrap), 0);
    chk("reset_lerr", int'(load_err), 0);
    @(negedge clk); #1;
    clear = 1'b0; en = 1'b1; up_dn = 1'b1;

`ifdef T_FF_MOD_COUNTER_SATURATE_EN
    for (int i = 1; i <= 15; i++) begin
      cyc();
      chk("sat_up_q", int'(q), (i < 9) ? i : 9);
      chk("sat_wrap", int'(wrap), 0);
      if (i >= 9) chk("sat_tc", int'(tc), 1);
    end
    up_dn = 1'b0;
    cyc();
    chk("sat_down_q", int'(q), 8);
    en = 1'b0; up_dn = 1'b1;
`else
    for (int i = 0; i < 12; i++) begin
      #1;
      chk("up_tc", int'(tc), (exp_up[i] == 0) ? 1 : 0);
      cyc();
      chk("up_q", int'(q), exp_up[i]);
      chk("up_wrap", int'(wrap), (i == 9) ? 1 : 0);
    end
    for (int i = 0; i < 8; i++) cyc();
    chk("pre_down_q", int'(q), 0);
    up_dn = 1'b0; #1;
    chk("down_tc_at0", int'(tc), 1);
    cyc();
    chk("down_q9", int'(q), 9);
    chk("down_wrap", int'(wrap), 1);
    chk("down_tc_at9", int'(tc), 0);
    cyc();
    chk("down_q8", int'(q), 8);
    chk("down_wrap8", int'(wrap), 0);
    cyc();
    chk("down_q7", int'(q), 7);
    up_dn = 1'b1;
`endif

    load = 1'b1; load_val = 4'd5; en = 1'b1;
    cyc();
    chk("load5_q", int'(q), 5);
    chk("load5_err", int'(load_err), 0);
    load_val = 4'd12;
    cyc();
    chk("load12_q", int'(q), 9);
    chk("load12_err", int'(load_err), 1);
    load = 1'b0; en = 1'b0;
    cyc();
    chk("hold_q", int'(q), 9);
    chk("err_one_cycle", int'(load_err), 0);
    load = 1'b1; load_val = 4'd10;
    cyc();
    chk("load10_q", int'(q), 9);
    chk("load10_err", int'(load_err), 1);
    load_val = 4'd9;
    cyc();
    chk("load9_q", int'(q), 9);
    chk("load9_err", int'(load_err), 0);

    load_val = 4'd6;
    cyc();
    chk("load6_q", int'(q), 6);
    sync_clr = 1'b1; load_val = 4'd12; en = 1'b1; up_dn = 1'b1;
    cyc();
    chk("sclr_q", int'(q), 0);
    chk("sclr_wrap", int'(wrap), 0);
    chk("sclr_lerr", int'(load_err), 0);
    sync_clr = 1'b0;
    load_val = 4'd7;
    cyc();
    chk("load7_q", int'(q), 7);
    load = 1'b0; en = 1'b0;

    #2;
    clear = 1'b1;
    #1;
    chk("aclr_q", int'(q), 0);
    chk("aclr_qbar", int'(qbar), 15);
    @(negedge clk); #1;
    clear = 1'b0; en = 1'b1; up_dn = 1'b1;
    cyc();
    chk("resume_q", int'(q), 1);
    cyc();
    chk("resume_q2", int'(q), 2);
    en = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
